axi4lite_uart_tx_fifo: RTL and testbench

//  AXI4-Lite slave UART transmitter with a TX FIFO, a programmable baud divider and a real serializer driving UART_TXD.

---
 rtl/axi4lite_uart_tx_fifo.sv | 215 +++++++++++++++++++++
 tb/tb_axi4lite_uart_tx_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_uart_tx_fifo.sv
// AXI4-Lite UART transmitter: TX FIFO, programmable baud divider and line serializer.
// Optional parity bit enabled by defining UART_PARITY_EN.
module axi4lite_uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_RESET  = 868
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        UART_TXD,
  output logic        IRQ
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic                 awready_q, arready_q, bvalid_q, rvalid_q;
  logic [1:0]           bresp_q;
  logic [31:0]          rdata_q, rd_mux;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [LW-1:0]        level_q;
  logic [15:0]          div_q, eff_div, baud_q;
  logic                 tx_en_q, irq_en_q, odd_par;
  state_e               state_q;
  logic                 txd_q, par_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 wr_acc, rd_acc, empty, full, push, pop, flush, wr_err, bit_done, busy;
  logic                 unused_bits;

  assign wr_acc   = awready_q & AWVALID & WVALID;
  assign rd_acc   = arready_q & ARVALID;
  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign wr_err   = wr_acc & (AWADDR[3:2] == 2'd0) & (!WSTRB[0] | full);
  assign push     = wr_acc & (AWADDR[3:2] == 2'd0) & WSTRB[0] & !full;
  assign flush    = wr_acc & (AWADDR[3:2] == 2'd3) & WDATA[1];
  assign eff_div  = (div_q < 16'd2) ? 16'd2 : div_q;
  assign bit_done = (baud_q == '0);
  assign busy     = (state_q != S_IDLE);
  // STOP may pop directly into the next START so frames run back-to-back.
  assign pop      = tx_en_q & !empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_done));

  assign AWREADY  = awready_q;
  assign WREADY   = awready_q;
  assign ARREADY  = arready_q;
  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign RVALID   = rvalid_q;
  assign RDATA    = rdata_q;
  assign RRESP    = 2'b00;
  assign UART_TXD = txd_q;
  assign IRQ      = irq_en_q & empty & !busy;

  assign unused_bits = ^{AWADDR[31:4], AWADDR[1:0], ARADDR[31:4], ARADDR[1:0], WDATA[31:16], WSTRB[3:1]};

  always_comb begin
    rd_mux = '0;
    case (ARADDR[3:2])
      2'd1:    rd_mux = {16'h0, 8'(level_q), 5'h0, busy, full, empty};
      2'd2:    rd_mux = {16'h0, div_q};
      2'd3:    rd_mux = {28'h0, odd_par, irq_en_q, 1'b0, tx_en_q};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      awready_q <= AWVALID & WVALID & !bvalid_q & !awready_q;
      arready_q <= ARVALID & !rvalid_q & !arready_q;
      if (wr_acc) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? 2'b10 : 2'b00;
      end else if (BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (rd_acc) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

`ifdef UART_PARITY_EN
  logic odd_par_q;
  assign odd_par = odd_par_q;
`else
  assign odd_par = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      div_q     <= 16'(DIV_RESET);
      tx_en_q   <= 1'b0;
      irq_en_q  <= 1'b0;
`ifdef UART_PARITY_EN
      odd_par_q <= 1'b0;
`endif
    end else if (wr_acc) begin
      if (AWADDR[3:2] == 2'd2) div_q <= WDATA[15:0];
      if (AWADDR[3:2] == 2'd3) begin
        tx_en_q   <= WDATA[0];
        irq_en_q  <= WDATA[2];
`ifdef UART_PARITY_EN
        odd_par_q <= WDATA[3];
`endif
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wptr_q] <= WDATA[DATA_BITS-1:0];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush) begin
      rptr_q  <= wptr_q;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      txd_q   <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else if (pop) begin
      state_q <= S_START;
      txd_q   <= 1'b0;
      baud_q  <= eff_div - 16'd1;
      shift_q <= mem_q[rptr_q];
      par_q   <= ^mem_q[rptr_q];
    end else if (busy && !bit_done) begin
      baud_q <= baud_q - 16'd1;
    end else begin
      baud_q <= eff_div - 16'd1;
      case (state_q)
        S_START: begin
          state_q <= S_DATA;
          txd_q   <= shift_q[0];
          bit_q   <= '0;
        end
        S_DATA: begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            state_q <= S_PARITY;
            txd_q   <= par_q ^ odd_par;
`else
            state_q <= S_STOP;
            txd_q   <= 1'b1;
`endif
          end else begin
            bit_q   <= bit_q + BW'(1);
            shift_q <= shift_q >> 1;
            txd_q   <= shift_q[1];
          end
        end
        S_PARITY: begin
          state_q <= S_STOP;
          txd_q   <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_uart_tx_fifo.sv
// Bench for axi4lite_uart_tx_fifo: register shadow model plus an expected line-waveform queue
// compared against UART_TXD every cycle. Parity scenarios run when UART_PARITY_EN is defined.
module tb_axi4lite_uart_tx_fifo;

  logic        ACLK = 1'b0, ARESET = 1'b1;
  logic        AWVALID = 1'b0, AWREADY, WVALID = 1'b0, WREADY, BVALID, BREADY = 1'b1;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0, RDATA;
  logic [3:0]  WSTRB = '0;
  logic [1:0]  BRESP, RRESP;
  logic        ARVALID = 1'b0, ARREADY, RVALID, RREADY = 1'b1;
  logic        UART_TXD, IRQ;

  axi4lite_uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_RESET(868)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .UART_TXD(UART_TXD), .IRQ(IRQ)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0, errors = 0;
  bit exp_q[$];
  bit mon_en = 0, mon_active = 0;
  logic [15:0] m_div = 16'd868;
  logic [3:0]  m_ctrl = '0;
  int          m_level = 0;
`ifdef UART_PARITY_EN
  localparam logic [3:0] CTRL_MASK = 4'b1101;
`else
  localparam logic [3:0] CTRL_MASK = 4'b0101;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status(input int level, input bit busy);
    return {16'h0, 8'(level), 5'h0, busy, level == 16, level == 0};
  endfunction

  // Append one frame's per-cycle line levels, using the divider/parity the model holds now.
  task automatic push_frame(input logic [7:0] b);
    int d;
    d = (m_div < 16'd2) ? 2 : int'(m_div);
    for (int k = 0; k < d; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < d; k++) exp_q.push_back(b[i]);
`ifdef UART_PARITY_EN
    for (int k = 0; k < d; k++) exp_q.push_back((^b) ^ m_ctrl[3]);
`endif
    for (int k = 0; k < d; k++) exp_q.push_back(1'b1);
  endtask

  always @(negedge ACLK) begin
    if (mon_en) begin
      if (!mon_active && exp_q.size() > 0 && UART_TXD === 1'b0) mon_active = 1;
      if (mon_active) begin
        chk("txd_frame", UART_TXD, exp_q.pop_front());
        if (exp_q.size() == 0) mon_active = 0;
      end else begin
        chk("txd_idle", UART_TXD, 1'b1);
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
    n = 0;
    do begin @(posedge ACLK); #1; n++; end while (!AWREADY && n < 20);
    chk("aw_handshake", {AWREADY, WREADY}, 2'b11);
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    n = 0;
    while (!BVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    chk("bvalid_seen", BVALID, 1'b1);
    resp = BRESP;
    @(posedge ACLK); #1;
  endtask

  task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_write(a, d, s, r);
    chk(name, r, exp_resp);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp, input int hold);
    int n;
    logic [31:0] d;
    ARADDR = a; ARVALID = 1; RREADY = (hold == 0);
    n = 0;
    do begin @(posedge ACLK); #1; n++; end while (!ARREADY && n < 20);
    chk("ar_handshake", ARREADY, 1'b1);
    @(posedge ACLK); #1;
    ARVALID = 0;
    n = 0;
    while (!RVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    chk("rvalid_seen", RVALID, 1'b1);
    d = RDATA;
    chk(name, d, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge ACLK); #1;
      chk("rvalid_hold", RVALID, 1'b1);
      chk("rdata_hold", RDATA, d);
    end
    RREADY = 1;
    @(posedge ACLK); #1;
    chk("rvalid_clear", RVALID, 1'b0);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < max) begin @(posedge ACLK); #1; n++; end
    chk("line_done_timeout", (exp_q.size() != 0 || mon_active), 1'b0);
  endtask

  task automatic wait_start(input int max);
    int n = 0;
    while (!mon_active && n < max) begin @(posedge ACLK); #1; n++; end
    chk("start_timeout", mon_active, 1'b1);
  endtask

  task automatic set_div(input logic [15:0] d);
    m_div = d;
    wr("bresp_div", 32'h8, {16'h0, d}, 4'hF, 2'b00);
  endtask

  task automatic set_ctrl(input logic [3:0] c);
    wr("bresp_ctrl", 32'hC, {28'h0, c}, 4'hF, 2'b00);
    m_ctrl = c & CTRL_MASK;
  endtask

  logic [47:0] v;

  initial begin
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_axi_ready", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b0);
    chk("rst_resp", {BRESP, RRESP}, 4'b0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_txd", UART_TXD, 1'b1);
    chk("rst_irq", IRQ, 1'b0);
    ARESET = 0;
    mon_en = 1;

    // reset register values; RDATA held while RREADY low
    rd("rst_bauddiv", 32'h8, 32'h364, 5);
    rd("rst_status", 32'h4, exp_status(0, 0), 0);
    rd("rst_ctrl", 32'hC, 32'h0, 0);
    rd("txdata_reads_0", 32'h0, 32'h0, 0);

    // single 0x55 frame at divider 4
    set_div(16'd4);
    set_ctrl(4'h1);
    push_frame(8'h55);
    v = '0;
    foreach (exp_q[i]) v = {v[46:0], exp_q[i]};
`ifdef UART_PARITY_EN
    chk("model_len_55", exp_q.size(), 44);
    chk("model_bits_55", v, 48'h0F0F0F0F00F);
`else
    chk("model_len_55", exp_q.size(), 40);
    chk("model_bits_55", v, 48'h0F0F0F0F0F);
`endif
    wr("bresp_tx55", 32'h0, 32'h55, 4'hF, 2'b00);
    wait_idle(200);
    repeat (3) @(posedge ACLK);
    #1;
    chk("irq_disabled", IRQ, 1'b0);
    rd("status_after_55", 32'h4, exp_status(0, 0), 0);

    // fill FIFO with tx disabled, overflow, then drain back-to-back
    set_ctrl(4'h0);
    set_div(16'd2);
    m_level = 0;
    for (int i = 0; i < 16; i++) begin
      push_frame(8'(i * 17 + 3));
      wr("bresp_fill", 32'h0, 32'(i * 17 + 3), 4'hF, 2'b00);
      m_level++;
    end
    rd("status_full", 32'h4, exp_status(m_level, 0), 0);
    chk("status_full_literal", exp_status(m_level, 0), 32'h1002);
    wr("bresp_overflow", 32'h0, 32'hEE, 4'hF, 2'b10);
    rd("status_after_ovf", 32'h4, exp_status(m_level, 0), 0);
    set_ctrl(4'h1);
    m_level = 0;
    wait_idle(16 * 24 + 100);
    rd("status_drained", 32'h4, exp_status(m_level, 0), 0);

    // divider 1 behaves as 2; strobe-less and STATUS writes
    set_div(16'd1);
    rd("bauddiv_raw", 32'h8, 32'h1, 0);
    push_frame(8'hC3);
    wr("bresp_txc3", 32'h0, 32'hC3, 4'hF, 2'b00);
    wait_idle(100);
    wr("bresp_nostrb", 32'h0, 32'h12, 4'hE, 2'b10);
    wr("bresp_status_wr", 32'h4, 32'hFFFF, 4'hF, 2'b00);
    rd("status_untouched", 32'h4, exp_status(0, 0), 0);
    repeat (5) @(posedge ACLK);

    // flush during the first of three queued frames
    set_div(16'd4);
    set_ctrl(4'h0);
    for (int i = 1; i <= 3; i++) wr("bresp_q3", 32'h0, 32'(i * 16'h11), 4'hF, 2'b00);
    push_frame(8'h11);
    set_ctrl(4'h5);
    wait_start(20);
    repeat (4) @(posedge ACLK);
    wr("bresp_flush", 32'hC, 32'h7, 4'hF, 2'b00);
    rd("ctrl_flush_clears", 32'hC, 32'h5, 0);
    rd("status_flushed_busy", 32'h4, exp_status(0, 1), 0);
    chk("irq_while_busy", IRQ, 1'b0);
    wait_idle(100);
    repeat (12) @(posedge ACLK);
    #1;
    chk("irq_idle_empty", IRQ, 1'b1);
    rd("status_after_flush", 32'h4, exp_status(0, 0), 0);

    // reset during DATA bit 3
    set_ctrl(4'h1);
    push_frame(8'hA5);
    wr("bresp_txa5", 32'h0, 32'hA5, 4'hF, 2'b00);
    wait_start(20);
    repeat (16) @(posedge ACLK);
    #1;
    mon_en = 0; mon_active = 0; exp_q.delete();
    ARESET = 1;
    @(posedge ACLK); #1;
    chk("txd_after_reset", UART_TXD, 1'b1);
    ARESET = 0;
    m_div = 16'd868; m_ctrl = '0; m_level = 0;
    mon_en = 1;
    rd("status_after_reset", 32'h4, exp_status(m_level, 0), 0);
    rd("bauddiv_after_reset", 32'h8, {16'h0, m_div}, 0);
    chk("bauddiv_model_pin", m_div, 16'h364);

`ifdef UART_PARITY_EN
    // parity bit, even then odd
    set_div(16'd2);
    set_ctrl(4'h1);
    push_frame(8'h07);
    chk("model_len_par", exp_q.size(), 22);
    chk("model_par_even", exp_q[18], 1'b1);
    wr("bresp_par0", 32'h0, 32'h07, 4'hF, 2'b00);
    wait_idle(60);
    set_ctrl(4'h9);
    rd("ctrl_odd_par", 32'hC, 32'h9, 0);
    push_frame(8'h07);
    chk("model_par_odd", exp_q[18], 1'b0);
    wr("bresp_par1", 32'h0, 32'h07, 4'hF, 2'b00);
    wait_idle(60);
`else
    wr("bresp_ctrl_bit3", 32'hC, 32'h9, 4'hF, 2'b00);
    m_ctrl = 4'h9 & CTRL_MASK;
    rd("ctrl_bit3_ignored", 32'hC, {28'h0, m_ctrl}, 0);
`endif

    repeat (10) @(posedge ACLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
